// File: rtl/pointer_render.sv
// Hardware pointer overlay: fetches one 32-pixel 4bpp row of the pointer image
// during horizontal blank, then draws it as a registered overlay pixel stream.
module pointer_render #(
    parameter int CWIDTH = 11,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_ni,
    input  logic              pointer_en_i,
    input  logic [CWIDTH-1:0] pointer_x_i,
    input  logic [CWIDTH-1:0] pointer_y_i,
    input  logic              hblank_start_i,
    input  logic [CWIDTH-1:0] next_line_i,
    input  logic [CWIDTH-1:0] h_count_i,
    output logic [AWIDTH-1:0] pm_addr_o,
    input  logic [15:0]       pm_data_i,
    output logic [3:0]        pixel_o,
    output logic              pixel_valid_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CWIDTH-1:0] w_row;
    logic [CWIDTH-1:0] w_p;
    logic [CWIDTH-1:0] r_x;
    logic [4:0]        r_row;
    logic [3:0]        r_idx;
    logic              r_line_valid;
    logic [AWIDTH-1:0] r_pm_addr;
    logic [15:0]       r_linebuf [8];
    logic [3:0]        r_pixel;
    logic              r_pixel_valid;
    logic              w_accept;
    logic              w_start;
    logic              w_fetch_done;
    logic              w_in_range;
    logic [15:0]       w_word;
    logic [3:0]        w_nib;

    assign w_row        = next_line_i - pointer_y_i;
    assign w_accept     = hblank_start_i && (r_state != FETCH);
    assign w_start      = w_accept && pointer_en_i && (w_row < CWIDTH'(32));
    assign w_fetch_done = (r_state == FETCH) && (r_idx == 4'd8);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, READY: begin
                if (hblank_start_i) begin
                    w_next = w_start ? FETCH : IDLE;
                end
            end
            FETCH: begin
                if (w_fetch_done) begin
                    w_next = READY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // r_idx counts address-issue cycles; word idx-1 arrives while idx is presented.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_idx        <= '0;
            r_pm_addr    <= '0;
            r_line_valid <= 1'b0;
            r_row        <= '0;
            r_x          <= '0;
        end else if (w_accept) begin
            r_line_valid <= 1'b0;
            if (w_start) begin
                r_row     <= w_row[4:0];
                r_x       <= pointer_x_i;
                r_idx     <= '0;
                r_pm_addr <= AWIDTH'({w_row[4:0], 3'd0});
            end
        end else if (r_state == FETCH) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx < 4'd7) begin
                r_pm_addr <= AWIDTH'({r_row, r_idx[2:0] + 3'd1});
            end
            if (w_fetch_done) begin
                r_line_valid <= 1'b1;
                r_idx        <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == FETCH && r_idx != 4'd0) begin
            r_linebuf[3'(r_idx - 4'd1)] <= pm_data_i;
        end
    end

    assign w_p        = h_count_i - r_x;
    assign w_in_range = r_line_valid && pointer_en_i && (w_p < CWIDTH'(32));
    assign w_word     = r_linebuf[w_p[4:2]];

    always_comb begin
        w_nib = '0;
        case (w_p[1:0])
            2'd0:    w_nib = w_word[15:12];
            2'd1:    w_nib = w_word[11:8];
            2'd2:    w_nib = w_word[7:4];
            default: w_nib = w_word[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel       <= w_in_range ? w_nib : 4'd0;
            r_pixel_valid <= w_in_range && (w_nib != 4'd0);
        end
    end

    assign pm_addr_o     = r_pm_addr;
    assign pixel_o       = r_pixel;
    assign pixel_valid_o = r_pixel_valid;
    assign busy_o        = (r_state == FETCH);

endmodule

// File: tb/tb_pointer_render.sv
// Randomized bench for pointer_render against a row/column arithmetic model of the pointer image.
module tb_pointer_render;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        pointer_en_i;
    logic [10:0] pointer_x_i;
    logic [10:0] pointer_y_i;
    logic        hblank_start_i;
    logic [10:0] next_line_i;
    logic [10:0] h_count_i;
    logic [7:0]  pm_addr_o;
    logic [15:0] pm_data_i;
    logic [3:0]  pixel_o;
    logic        pixel_valid_o;
    logic        busy_o;

    logic [15:0] mem [256];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model: which image row is loaded, where it sits, and whether it is drawable.
    bit          mv   = 1'b0;
    logic [4:0]  mrow = '0;
    logic [10:0] mx   = '0;

    int dir_h   [6] = '{199, 200, 201, 202, 203, 232};
    int dir_pix [6] = '{0, 1, 2, 3, 0, 0};
    int dir_v   [6] = '{0, 1, 1, 1, 0, 0};

    pointer_render #(.CWIDTH(11), .AWIDTH(8)) dut (
        .clk            (clk),
        .reset_ni       (reset_ni),
        .pointer_en_i   (pointer_en_i),
        .pointer_x_i    (pointer_x_i),
        .pointer_y_i    (pointer_y_i),
        .hblank_start_i (hblank_start_i),
        .next_line_i    (next_line_i),
        .h_count_i      (h_count_i),
        .pm_addr_o      (pm_addr_o),
        .pm_data_i      (pm_data_i),
        .pixel_o        (pixel_o),
        .pixel_valid_o  (pixel_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pm_data_i <= mem[pm_addr_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] exp_pix(input logic [10:0] h);
        logic [10:0] p;
        logic [15:0] w;
        int          nib;
        p = h - mx;
        if (!(mv && pointer_en_i && p < 11'd32)) return 5'd0;
        w   = mem[int'(mrow) * 8 + int'(p) / 4];
        nib = (int'(w) >> (12 - 4 * (int'(p) % 4))) & 15;
        return {nib != 0, 4'(nib)};
    endfunction

    // glitch: cycle at which a second pulse arrives; abort: cycle at which reset hits.
    task automatic do_pulse(input logic [10:0] nl, input int glitch, input int abort);
        logic [10:0] row;
        bit          go;
        row = nl - pointer_y_i;
        go  = pointer_en_i && (row < 11'd32);
        hblank_start_i = 1'b1;
        next_line_i    = nl;
        tick();
        hblank_start_i = 1'b0;
        mv = 1'b0;
        if (!go) begin
            for (int c = 1; c <= 3; c++) begin
                check("busy_nofetch", busy_o, 0);
                tick();
            end
            return;
        end
        mrow = row[4:0];
        mx   = pointer_x_i;
        for (int c = 1; c <= 9; c++) begin
            if (c == abort) begin
                reset_ni = 1'b0;
                #1;
                check("rst_addr", pm_addr_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_pix", pixel_o, 0);
                check("rst_valid", pixel_valid_o, 0);
                tick();
                reset_ni = 1'b1;
                tick();
                return;
            end
            if (c <= 8) check("addr", pm_addr_o, {24'd0, mrow, 3'(c - 1)});
            check("busy_fetch", busy_o, 1);
            if (c == glitch) begin
                hblank_start_i = 1'b1;
                next_line_i    = nl + 11'd1;
            end else begin
                hblank_start_i = 1'b0;
            end
            tick();
        end
        hblank_start_i = 1'b0;
        check("busy_done", busy_o, 0);
        mv = 1'b1;
    endtask

    task automatic sweep(input int n_rand);
        logic [4:0] e;
        for (int off = -2; off <= 34; off++) begin
            h_count_i = pointer_x_i + 11'(off);
            e = exp_pix(h_count_i);
            tick();
            check("pix", pixel_o, e[3:0]);
            check("pvalid", pixel_valid_o, e[4]);
        end
        for (int i = 0; i < n_rand; i++) begin
            h_count_i = 11'($urandom_range(0, 2047));
            e = exp_pix(h_count_i);
            tick();
            check("pix_rnd", pixel_o, e[3:0]);
            check("pvalid_rnd", pixel_valid_o, e[4]);
        end
    endtask

    initial begin
        logic [4:0] e;
        reset_ni       = 1'b0;
        pointer_en_i   = 1'b0;
        pointer_x_i    = '0;
        pointer_y_i    = '0;
        hblank_start_i = 1'b0;
        next_line_i    = '0;
        h_count_i      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        tick();
        tick();
        check("reset_addr", pm_addr_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_pix", pixel_o, 0);
        check("reset_valid", pixel_valid_o, 0);
        reset_ni = 1'b1;
        tick();

        // Directed row: word 0x1230 at x=200, row 5.
        pointer_en_i = 1'b1;
        pointer_y_i  = 11'd100;
        pointer_x_i  = 11'd200;
        mem[8'h28]   = 16'h1230;
        do_pulse(11'd105, 0, 0);
        for (int i = 0; i < 6; i++) begin
            h_count_i = 11'(dir_h[i]);
            tick();
            check("dir_pix", pixel_o, dir_pix[i]);
            check("dir_valid", pixel_valid_o, dir_v[i]);
        end
        sweep(4);

        pointer_en_i = 1'b0;
        h_count_i    = 11'd201;
        tick();
        check("en_drop_valid", pixel_valid_o, 0);
        pointer_en_i = 1'b1;

        // Vertical bounds
        do_pulse(11'd99, 0, 0);
        sweep(0);
        do_pulse(11'd131, 0, 0);
        sweep(4);
        do_pulse(11'd132, 0, 0);
        sweep(0);

        pointer_en_i = 1'b0;
        do_pulse(11'd105, 0, 0);
        pointer_en_i = 1'b1;
        sweep(0);

        do_pulse(11'd105, 3, 0);
        sweep(4);

        do_pulse(11'd110, 0, 4);
        sweep(4);
        do_pulse(11'd110, 0, 0);
        sweep(4);

        for (int t = 0; t < 30; t++) begin
            pointer_y_i  = 11'($urandom_range(0, 2047));
            pointer_x_i  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2016, 2047))
                                                       : 11'($urandom_range(0, 2047));
            pointer_en_i = ($urandom_range(0, 5) != 0);
            do_pulse(pointer_y_i + 11'($urandom_range(0, 40)) - 11'd4, 0, 0);
            sweep(6);
            if (mv) begin
                pointer_en_i = 1'b0;
                h_count_i    = mx;
                e            = exp_pix(h_count_i);
                tick();
                check("rnd_en_drop", pixel_valid_o, e[4]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
